// File: rtl/pe_pkg.sv
// Shared widths, saturation limits, drain FSM states and the requantization helper
// used by the PE column drain.
package pe_pkg;

  localparam int DATA_W  = 8;
  localparam int SUM_W   = 16;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // ReLU first, then arithmetic shift, then clamp to the signed 8-bit range.
  function automatic logic [DATA_W-1:0] requant(input logic [SUM_W-1:0] sum,
                                               input logic relu,
                                               input int shift);
    logic signed [SUM_W-1:0] v;
    int vi;
    v = (relu && sum[SUM_W-1]) ? '0 : $signed(sum);
    v = v >>> shift;
    vi = int'(v);
    if (vi > SAT_MAX) vi = SAT_MAX;
    if (vi < SAT_MIN) vi = SAT_MIN;
    return vi[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; the head word reads as zero while empty so idle outputs stay clean.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // A read at full frees the slot the same-edge write lands in.
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pe_drain.sv
// PE column drain: requantizes partial sums from the last PE of a column and
// buffers them, tagged with an end-of-burst flag, for a downstream consumer.
module pe_drain
  import pe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SHIFT = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   activein,
  input  logic [SUM_W-1:0]       sumin,
  input  logic                   relu_en,
  input  logic                   flush,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy
);
  logic              stage_valid_q, stage_valid_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic              overflow_q, overflow_d;
  state_e            state_q, state_d;
  logic              fifo_empty, fifo_full;
  logic              fifo_wr, fifo_rd;
  logic [DATA_W:0]   wr_word, rd_word;

  always_comb begin
    stage_valid_d = activein;
    stage_data_d  = activein ? requant(sumin, relu_en, SHIFT) : stage_data_q;
    fifo_wr       = stage_valid_q & ~flush;
    fifo_rd       = out_ready & ~flush;
    // The sample that arrives with activein low ends the burst.
    wr_word       = {~activein, stage_data_q};
    overflow_d    = overflow_q | (stage_valid_q & fifo_full & ~out_ready);
    state_d       = state_q;
    unique case (state_q)
      ST_IDLE:   if (activein) state_d = ST_STREAM;
      ST_STREAM: if (!activein) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (activein) state_d = ST_STREAM;
        else if (!stage_valid_q && fifo_empty) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (flush) begin
      stage_valid_d = 1'b0;
      stage_data_d  = '0;
      overflow_d    = 1'b0;
      state_d       = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      overflow_q    <= 1'b0;
      state_q       <= ST_IDLE;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_data_q  <= stage_data_d;
      overflow_q    <= overflow_d;
      state_q       <= state_d;
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .clear  (flush),
    .wr_en  (fifo_wr),
    .wr_data(wr_word),
    .rd_en  (fifo_rd),
    .rd_data(rd_word),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (count)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = rd_word[DATA_W-1:0];
  assign out_last  = rd_word[DATA_W];
  assign overflow  = overflow_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_drain.sv
// Self-checking bench for pe_drain: requantization table, burst timing, full/overflow
// corners, reset/flush, then a randomized run against a queue-based reference model.
module tb_pe_drain;
  localparam int DEPTH = 8;
  localparam int SHIFT = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          activein = 1'b0;
  logic          relu_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   sumin = '0;
  logic          out_valid, out_last, overflow, busy;
  logic [7:0]    out_data;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] sum;
    logic        relu;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } ent_t;

  vec_t        vecs[15];
  ent_t        mq[$];
  logic [15:0] samp[10];

  always #5 clock = ~clock;

  pe_drain #(.DEPTH(DEPTH), .SHIFT(SHIFT)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .activein (activein),
    .sumin    (sumin),
    .relu_en  (relu_en),
    .flush    (flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .count    (count),
    .overflow (overflow),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Floor division by 2**SHIFT, then clamp: the arithmetic meaning of the requantizer.
  function automatic logic [7:0] ref_requant(input logic [15:0] raw, input bit relu);
    int s, d, q;
    s = int'($signed(raw));
    if (relu && s < 0) s = 0;
    d = 1 << SHIFT;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_data"}, 32'(out_data), 0);
    check({tag, "_last"}, 32'(out_last), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_ovf"}, 32'(overflow), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    bit          m_stage_v;
    logic [7:0]  m_stage_d;
    bit          m_ovf;
    bit          rd;
    ent_t        e;

    vecs[0]  = '{16'h0100, 1'b0, 8'h10};
    vecs[1]  = '{16'h7FFF, 1'b0, 8'h7F};
    vecs[2]  = '{16'hFF00, 1'b0, 8'hF0};
    vecs[3]  = '{16'h8000, 1'b0, 8'h80};
    vecs[4]  = '{16'hFF00, 1'b1, 8'h00};
    vecs[5]  = '{16'h0000, 1'b0, 8'h00};
    vecs[6]  = '{16'h000F, 1'b0, 8'h00};
    vecs[7]  = '{16'hFFFF, 1'b0, 8'hFF};
    vecs[8]  = '{16'h0800, 1'b0, 8'h7F};
    vecs[9]  = '{16'h07F0, 1'b0, 8'h7F};
    vecs[10] = '{16'hF800, 1'b0, 8'h80};
    vecs[11] = '{16'hF7F0, 1'b0, 8'h80};
    vecs[12] = '{16'hFFF1, 1'b0, 8'hFF};
    vecs[13] = '{16'h8000, 1'b1, 8'h00};
    vecs[14] = '{16'h0100, 1'b1, 8'h10};

    // Reset state
    #1 resetn = 1'b0;
    #1 check_all_zero("reset");
    step();
    step();
    resetn = 1'b1;

    // Requantization table: one single-sample burst per vector
    for (int i = 0; i < 15; i++) begin
      activein = 1'b1; sumin = vecs[i].sum; relu_en = vecs[i].relu; out_ready = 1'b0;
      step();
      activein = 1'b0;
      step();
      $display("vec %0d: sumin=%h relu=%0b -> out_data=%h (want %h)",
               i, vecs[i].sum, vecs[i].relu, out_data, vecs[i].exp);
      check("vec_valid", 32'(out_valid), 1);
      check("vec_data", 32'(out_data), 32'(vecs[i].exp));
      check("vec_last", 32'(out_last), 1);
      check("vec_count", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("vec_drained", 32'(out_valid), 0);
    end
    relu_en = 1'b0;
    step();
    step();

    // 3-sample burst with out_ready held high
    out_ready = 1'b1;
    activein = 1'b1; sumin = 16'h0100;
    step();
    check("burst_valid_e0", 32'(out_valid), 0);
    check("burst_busy", 32'(busy), 1);
    sumin = 16'h0200;
    step();
    check("burst_valid_e1", 32'(out_valid), 1);
    check("burst_d0", 32'(out_data), 32'h10);
    check("burst_l0", 32'(out_last), 0);
    sumin = 16'h0300;
    step();
    check("burst_d1", 32'(out_data), 32'h20);
    check("burst_l1", 32'(out_last), 0);
    activein = 1'b0;
    step();
    check("burst_d2", 32'(out_data), 32'h30);
    check("burst_l2", 32'(out_last), 1);
    step();
    check("burst_empty", 32'(out_valid), 0);
    step();
    step();
    check("burst_idle", 32'(busy), 0);
    $display("burst: 3 samples drained");

    // 10 samples into an 8-deep FIFO with no reads
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      samp[i] = 16'($urandom);
      activein = 1'b1; sumin = samp[i];
      step();
    end
    activein = 1'b0;
    step();
    check("ovf_count", 32'(count), DEPTH);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_hold", 32'(out_data), 32'(ref_requant(samp[0], 1'b0)));
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_drain_valid", 32'(out_valid), 1);
      check("ovf_drain_data", 32'(out_data), 32'(ref_requant(samp[i], 1'b0)));
      step();
    end
    check("ovf_drain_empty", 32'(out_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);
    out_ready = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check("ovf_flush", 32'(overflow), 0);
    $display("overflow: 10 in, 8 kept");

    // Full FIFO with simultaneous read and write
    for (int i = 0; i < 10; i++) begin
      samp[i] = 16'($urandom);
      activein = 1'b1; sumin = samp[i];
      out_ready = (i == 9);
      step();
      if (i == 8) check("full_count", 32'(count), DEPTH);
    end
    activein = 1'b0; out_ready = 1'b0;
    check("full_rw_count", 32'(count), DEPTH);
    check("full_rw_ovf", 32'(overflow), 0);
    check("full_rw_head", 32'(out_data), 32'(ref_requant(samp[1], 1'b0)));
    flush = 1'b1;
    step();
    flush = 1'b0;
    $display("full read+write: count held");

    // Reset pulsed mid-burst
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      activein = 1'b1; sumin = 16'h0400 + 16'(i);
      step();
    end
    #2 resetn = 1'b0;
    #1 check_all_zero("midrst");
    step();
    check("midrst_hold_count", 32'(count), 0);
    check("midrst_hold_busy", 32'(busy), 0);
    resetn = 1'b1; activein = 1'b0;
    step();
    check("midrst_after_count", 32'(count), 0);
    check("midrst_after_busy", 32'(busy), 0);
    $display("mid-burst reset: outputs cleared");

    // Flush with 4 entries buffered, competing with a write and a read
    for (int i = 0; i < 4; i++) begin
      activein = 1'b1; sumin = 16'h1000 + 16'(i << 4);
      step();
    end
    activein = 1'b0;
    step();
    check("flush_pre_count", 32'(count), 4);
    flush = 1'b1; activein = 1'b1; out_ready = 1'b1; sumin = 16'h0123;
    step();
    flush = 1'b0; activein = 1'b0; out_ready = 1'b0;
    check_all_zero("flush");
    $display("flush: 4 entries cleared");

    // Randomized traffic against the reference model
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_stage_v = 1'b0; m_stage_d = '0; m_ovf = 1'b0;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      activein  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      relu_en   = $urandom_range(0, 1) != 0;
      sumin     = 16'($urandom);
      rd = (mq.size() > 0) && out_ready;
      if (rd) void'(mq.pop_front());
      if (m_stage_v) begin
        if (mq.size() < DEPTH) begin
          e.data = m_stage_d;
          e.last = !activein;
          mq.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_stage_v = activein;
      if (activein) m_stage_d = ref_requant(sumin, relu_en);
      step();
      check("rnd_valid", 32'(out_valid), (mq.size() > 0) ? 1 : 0);
      check("rnd_count", 32'(count), mq.size());
      check("rnd_ovf", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        check("rnd_data", 32'(out_data), 32'(mq[0].data));
        check("rnd_last", 32'(out_last), 32'(mq[0].last));
      end
    end
    $display("random: 400 cycles, %0d entries left", mq.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
